disp_cost_ser: RTL and testbench
================================

Name: disp_cost_ser

Overview:
- Serialiser that feeds the disparity winner-take-all path, sitting upstream of the comparator.
- Accepts one packed vector of D matching costs per pixel through a valid/ready handshake.
- Emits the costs as a stream of (cost, disparity) beats, disparity 0 first, with a last flag on the final beat.
- Downstream, a single time-multiplexed comparator stage reduces the stream to the winning disparity, replacing a full comparator tree.

Parameters:
- WC, 3, census window size; used only to derive CBIT.
- WH, 7, aggregation window size; used only to derive CBIT.
- D, 64, number of disparity candidates; must be >= 2.
- Derived localparam DBIT = $clog2(D).
- Derived localparam CBIT = $clog2(((WC**2)/2)*(WH**2)); defaults give CBIT=8, DBIT=6.

Ports:
- i_clk  input  1  clock; all state on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  cost vector valid.
- o_ready  output  1  serialiser can accept a vector.
- i_cost_vec  input  D*CBIT  packed costs; slice [k*CBIT +: CBIT] is the cost of disparity k.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream accepts the beat.
- o_data_c  output  CBIT  cost of the current beat.
- o_data_d  output  DBIT  disparity index of the current beat.
- o_last  output  1  beat carries disparity D-1.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; o_valid=0, o_last=0, o_data_c=0, o_data_d=0.
  - Internal vector register and counter cleared; o_ready=1 once out of reset.
- States:
  - IDLE: o_valid=0. On i_valid&&o_ready, capture i_cost_vec, go to STREAM. Next cycle o_valid=1, o_data_d=0, o_data_c=cost[0].
  - STREAM: beat k is presented (o_data_d=k, o_data_c=cost[k]).
    - On i_valid... no input needed; on o_valid&&i_ready with k<D-1, advance to k+1.
    - On the handshake with k=D-1 (o_last=1): if i_valid&&o_ready in the same cycle, load the new vector and present its beat 0 next cycle (no bubble). Otherwise return to IDLE with o_valid=0.
- o_ready = (state==IDLE) || (o_last && i_ready). This is the only combinational path, from i_ready to o_ready; all data outputs are registered.
- Stall: while o_valid && !i_ready, o_data_c, o_data_d and o_last hold stable. i_cost_vec is ignored unless o_ready is high.
- Throughput: D beats per vector with zero-bubble back-to-back operation. Latency from acceptance to first beat is 1 cycle.
- Counter: runs 0..D-1 and does not assume D is a power of two. D-1 is the terminal count; there is no wrap past D-1.
- Reset asserted mid-stream: the vector in progress is discarded, outputs go to reset values immediately, and no partial last is emitted.

Optional Feature:
- Macro: DISP_COST_SER_MINTRACK_EN.
- With the macro defined, the block adds ports o_min_valid (1), o_min_c (CBIT) and o_min_d (DBIT), and keeps a running minimum over accepted beats.
  - Update rule: replace the held value only when the new cost < held cost (strict), so on ties the lower disparity wins, matching the comparator.
  - On the o_last handshake: o_min_c/o_min_d register the final result and o_min_valid pulses high for exactly 1 cycle.
  - Reset values are 0.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Shared package stereo_pkg holds:
  - CBIT/DBIT derivation functions from WC, WH, D.
  - The state enum (IDLE, STREAM).
- Natural sub-module: the min tracker reuses disp_cmp, instantiated only under DISP_COST_SER_MINTRACK_EN.

Test Plan:
- D=64, costs cost[k]=k, i_ready tied 1 -> 64 consecutive beats with d=0..63, o_last only on d=63, o_ready low throughout streaming.
- Two vectors presented back-to-back, i_valid held -> beat 0 of vector 2 follows d=63 of vector 1 with no idle cycle; 128 total beats in 129 cycles from first acceptance.
- Random i_ready (50%) -> beat values stay stable during stalls; the sequence is still 0..63 with no duplicated or dropped beat.
- i_rst_n pulsed low at beat d=20 -> o_valid=0 immediately; the next vector starts at d=0 with o_last only at d=63.
- MINTRACK on, costs all 200 except cost[5]=cost[40]=3 -> o_min_c=3, o_min_d=5, o_min_valid high for 1 cycle after the d=63 handshake.
- D=5 (non-power-of-two) -> beats d=0..4, o_last on d=4, counter never reaches 5–7.

Source files
------------

// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared widths and state encoding for the disparity cost path
package stereo_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  // Largest aggregated census cost is (WC^2/2) bits per window times WH^2 windows.
  function automatic int cbit_f(input int wc, input int wh);
    return $clog2(((wc ** 2) / 2) * (wh ** 2));
  endfunction

  function automatic int dbit_f(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/disp_cmp.sv
// rtl/disp_cmp.sv - one comparator step of the winner-take-all reduction
module disp_cmp #(
  parameter int CBIT = 8,
  parameter int DBIT = 6
) (
  input  logic [CBIT-1:0] a_c,
  input  logic [DBIT-1:0] a_d,
  input  logic [CBIT-1:0] b_c,
  input  logic [DBIT-1:0] b_d,
  output logic [CBIT-1:0] win_c,
  output logic [DBIT-1:0] win_d
);

  // Strict compare: on a tie the incumbent (lower disparity) is kept.
  logic b_wins;
  assign b_wins = (b_c < a_c);
  assign win_c  = b_wins ? b_c : a_c;
  assign win_d  = b_wins ? b_d : a_d;

endmodule

// File: rtl/disp_cost_ser.sv
// rtl/disp_cost_ser.sv - cost vector to (cost, disparity) beat serialiser; DISP_COST_SER_MINTRACK_EN adds a running minimum
module disp_cost_ser
  import stereo_pkg::*;
#(
  parameter int    WC   = 3,
  parameter int    WH   = 7,
  parameter int    D    = 64,
  localparam int   DBIT = dbit_f(D),
  localparam int   CBIT = cbit_f(WC, WH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [D*CBIT-1:0]   i_cost_vec,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [CBIT-1:0]     o_data_c,
  output logic [DBIT-1:0]     o_data_d,
  output logic                o_last
`ifdef DISP_COST_SER_MINTRACK_EN
 ,output logic                o_min_valid,
  output logic [CBIT-1:0]     o_min_c,
  output logic [DBIT-1:0]     o_min_d
`endif
);

  ser_state_e          state;
  logic [D*CBIT-1:0]   vec;
  logic [DBIT-1:0]     cnt;
  logic                load;
  logic                advance;
  logic                to_idle;

  assign o_ready  = (state == IDLE) || (o_last && i_ready);
  assign o_data_d = cnt;

  assign load    = i_valid && o_ready;
  assign advance = (state == STREAM) && i_ready && !o_last;
  assign to_idle = (state == STREAM) && i_ready && o_last && !i_valid;

  // The vector shifts down one cost per beat so the next cost is always in slot 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data_c <= '0;
    end else if (load) begin
      state    <= STREAM;
      vec      <= i_cost_vec;
      cnt      <= '0;
      o_valid  <= 1'b1;
      o_last   <= 1'b0;
      o_data_c <= i_cost_vec[CBIT-1:0];
    end else if (advance) begin
      vec      <= vec >> CBIT;
      cnt      <= cnt + DBIT'(1);
      o_last   <= (cnt == DBIT'(D - 2));
      o_data_c <= vec[2*CBIT-1 -: CBIT];
    end else if (to_idle) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end
  end

`ifdef DISP_COST_SER_MINTRACK_EN
  logic            beat_fire;
  logic [CBIT-1:0] run_c;
  logic [DBIT-1:0] run_d;
  logic [CBIT-1:0] ref_c;
  logic [DBIT-1:0] ref_d;
  logic [CBIT-1:0] win_c;
  logic [DBIT-1:0] win_d;

  assign beat_fire = o_valid && i_ready;
  // Beat 0 seeds the tracker by comparing against itself.
  assign ref_c = (cnt == '0) ? o_data_c : run_c;
  assign ref_d = (cnt == '0) ? cnt      : run_d;

  disp_cmp #(
    .CBIT (CBIT),
    .DBIT (DBIT)
  ) u_cmp (
    .a_c   (ref_c),
    .a_d   (ref_d),
    .b_c   (o_data_c),
    .b_d   (cnt),
    .win_c (win_c),
    .win_d (win_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_c       <= '0;
      run_d       <= '0;
      o_min_c     <= '0;
      o_min_d     <= '0;
      o_min_valid <= 1'b0;
    end else begin
      o_min_valid <= 1'b0;
      if (beat_fire) begin
        run_c <= win_c;
        run_d <= win_d;
        if (o_last) begin
          o_min_c     <= win_c;
          o_min_d     <= win_d;
          o_min_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_disp_cost_ser.sv
// tb/tb_disp_cost_ser.sv - directed bench for disp_cost_ser at D=64 and D=5
module tb_disp_cost_ser;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid, ready;
  logic [511:0] vec;
  logic         o_ready_w, o_valid_w, o_last_w;
  logic [7:0]   o_c;
  logic [5:0]   o_d;

  logic         v5, r5;
  logic [39:0]  vec5;
  logic         rdy5_w, val5_w, last5_w;
  logic [7:0]   c5;
  logic [2:0]   d5;

`ifdef DISP_COST_SER_MINTRACK_EN
  logic         min_valid, min_valid5;
  logic [7:0]   min_c, min_c5;
  logic [5:0]   min_d;
  logic [2:0]   min_d5;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  disp_cost_ser #(.WC(3), .WH(7), .D(64)) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .o_ready    (o_ready_w),
    .i_cost_vec (vec),
    .o_valid    (o_valid_w),
    .i_ready    (ready),
    .o_data_c   (o_c),
    .o_data_d   (o_d),
    .o_last     (o_last_w)
`ifdef DISP_COST_SER_MINTRACK_EN
   ,.o_min_valid(min_valid),
    .o_min_c    (min_c),
    .o_min_d    (min_d)
`endif
  );

  disp_cost_ser #(.WC(3), .WH(7), .D(5)) u_dut5 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (v5),
    .o_ready    (rdy5_w),
    .i_cost_vec (vec5),
    .o_valid    (val5_w),
    .i_ready    (r5),
    .o_data_c   (c5),
    .o_data_d   (d5),
    .o_last     (last5_w)
`ifdef DISP_COST_SER_MINTRACK_EN
   ,.o_min_valid(min_valid5),
    .o_min_c    (min_c5),
    .o_min_d    (min_d5)
`endif
  );

  typedef struct packed {
    logic [39:0] costs;
    logic [7:0]  rdy;
    logic [7:0]  min_c;
    logic [2:0]  min_d;
  } rec_t;

  rec_t tbl [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_vec(input int mode);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) begin
      case (mode)
        0:       v[k*8 +: 8] = 8'(k);
        1:       v[k*8 +: 8] = 8'(63 - k);
        2:       v[k*8 +: 8] = 8'((k * 37 + 11) & 255);
        default: v[k*8 +: 8] = (k == 5 || k == 40) ? 8'd3 : 8'd200;
      endcase
    end
    return v;
  endfunction

  // Accept one vector with i_ready held high and check all 64 beats; ends just after the last handshake.
  task automatic full_stream(input logic [511:0] v, input string tag);
    logic [16:0] exp;
    valid = 1'b1; vec = v; ready = 1'b1;
    #1;
    check({tag, " ready in idle"}, 64'(o_ready_w), 64'd1);
    tick();
    valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      exp = {1'b1, 1'(k == 63), 1'(k == 63), 6'(k), v[k*8 +: 8]};
      check($sformatf("%s beat %0d", tag, k), 64'({o_valid_w, o_last_w, o_ready_w, o_d, o_c}), 64'(exp));
      tick();
    end
    #1;
    check({tag, " idle after"}, 64'({o_valid_w, o_last_w, o_ready_w}), 64'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] va, vb, vc;
    logic [16:0]  exp, cur, prev;
    logic [15:0]  exp5;
    logic         stalled;
    int           ek, k5, j;

    va = make_vec(0);
    vb = make_vec(1);
    vc = make_vec(2);

    tbl[0] = '{costs: {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, rdy: 8'hFF,        min_c: 8'd10, min_d: 3'd0};
    tbl[1] = '{costs: {8'd7, 8'd3, 8'd3, 8'd9, 8'd9},      rdy: 8'b01011010,  min_c: 8'd3,  min_d: 3'd2};
    tbl[2] = '{costs: {8'd1, 8'd0, 8'd255, 8'd0, 8'd255},  rdy: 8'b10010011,  min_c: 8'd0,  min_d: 3'd1};
    tbl[3] = '{costs: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5},      rdy: 8'b00110111,  min_c: 8'd1,  min_d: 3'd4};

    rst_n = 1'b0; valid = 1'b0; ready = 1'b0; vec = '0;
    v5 = 1'b0; r5 = 1'b0; vec5 = '0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    #1;
    check("reset outputs d64", 64'({o_valid_w, o_last_w, o_d, o_c}), 64'd0);
    check("reset ready d64", 64'(o_ready_w), 64'd1);
    check("reset outputs d5", 64'({val5_w, last5_w, d5, c5}), 64'd0);
`ifdef DISP_COST_SER_MINTRACK_EN
    check("reset min d64", 64'({min_valid, min_c, min_d}), 64'd0);
`endif
    tick();

    full_stream(va, "ramp");

    // Back-to-back: vector B loads on the d=63 handshake of vector A.
    tick();
    valid = 1'b1; vec = va; ready = 1'b1;
    tick();
    vec = vb;
    for (int i = 0; i < 128; i++) begin
      if (i == 64) valid = 1'b0;
      #1;
      exp = {1'b1, 1'(i % 64 == 63), 1'(i % 64 == 63), 6'(i % 64),
             (i < 64) ? va[(i % 64)*8 +: 8] : vb[(i % 64)*8 +: 8]};
      check($sformatf("b2b beat %0d", i), 64'({o_valid_w, o_last_w, o_ready_w, o_d, o_c}), 64'(exp));
      tick();
    end
    #1;
    check("b2b idle after 128", 64'(o_valid_w), 64'd0);

    // Random back-pressure: stalled beats must hold, sequence must be complete.
    tick();
    valid = 1'b1; vec = vc; ready = 1'b1;
    tick();
    valid = 1'b0;
    ek = 0; stalled = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 600 && ek < 64; cyc++) begin
      ready = 1'($urandom_range(0, 1));
      #1;
      cur = {o_valid_w, o_last_w, 1'b0, o_d, o_c};
      if (stalled) check($sformatf("stall hold cyc %0d", cyc), 64'(cur), 64'(prev));
      if (o_valid_w && ready) begin
        exp = {1'b1, 1'(ek == 63), 1'b0, 6'(ek), vc[ek*8 +: 8]};
        check($sformatf("rand beat %0d", ek), 64'(cur), 64'(exp));
        ek++;
      end
      stalled = o_valid_w && !ready;
      prev = cur;
      tick();
    end
    check("rand beat count", 64'(ek), 64'd64);
    ready = 1'b1;
    #1;
    check("rand idle after", 64'(o_valid_w), 64'd0);

    // Reset asserted while d=20 is on the output.
    tick();
    valid = 1'b1; vec = va; ready = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("pre-reset at d20", 64'({o_valid_w, o_d}), 64'({1'b1, 6'd20}));
    rst_n = 1'b0;
    #1;
    check("async reset clears", 64'({o_valid_w, o_last_w, o_d, o_c}), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("held idle after reset", 64'({o_valid_w, o_ready_w}), 64'b01);
    tick();
    full_stream(vb, "post-reset");

`ifdef DISP_COST_SER_MINTRACK_EN
    tick();
    full_stream(make_vec(3), "mintrack");
    check("min result d64", 64'({min_valid, min_c, min_d}), 64'({1'b1, 8'd3, 6'd5}));
    tick();
    check("min pulse one cycle", 64'(min_valid), 64'd0);
`endif

    // D=5 table: non-power-of-two terminal count under varied back-pressure.
    for (int t = 0; t < 4; t++) begin
      tick();
      v5 = 1'b1; vec5 = tbl[t].costs; r5 = 1'b0;
      tick();
      v5 = 1'b0;
      k5 = 0; j = 0;
      for (int cyc = 0; cyc < 20 && k5 < 5; cyc++) begin
        r5 = tbl[t].rdy[j % 8];
        j++;
        #1;
        if (val5_w && r5) begin
          exp5 = {1'b1, 1'(k5 == 4), 3'(k5), 8'(tbl[t].costs >> (k5 * 8))};
          check($sformatf("d5 rec %0d beat %0d", t, k5), 64'({val5_w, last5_w, d5, c5}), 64'({exp5[15:0]}));
          k5++;
        end else if (val5_w) begin
          check($sformatf("d5 rec %0d stall d", t), 64'(d5 <= 3'd4), 64'd1);
        end
        tick();
      end
      check($sformatf("d5 rec %0d beat count", t), 64'(k5), 64'd5);
      #1;
      check($sformatf("d5 rec %0d idle", t), 64'({val5_w, rdy5_w}), 64'b01);
`ifdef DISP_COST_SER_MINTRACK_EN
      check($sformatf("d5 rec %0d min", t), 64'({min_valid5, min_c5, min_d5}),
            64'({1'b1, tbl[t].min_c, tbl[t].min_d}));
`endif
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
